// File: rtl/pc_unit.sv
// Program-counter unit: fetch address, stall/redirect, trap entry/return,
// debug halt/resume, double-fault lock-up and retired-instruction counter.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned     ILEN         = 4,
    parameter int unsigned     CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_req,
    input  logic             trap_ret,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  epc,
    output logic [1:0]       cause,
    output logic             trap_taken,
    output logic             halted,
    output logic             locked,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        RUN,
        HALTED,
        LOCKED
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN);

    state_t           state, state_nx;
    logic [XLEN-1:0]  pc_nx, epc_nx;
    logic [1:0]       cause_nx;
    logic             in_trap, in_trap_nx;
    logic             trap_taken_nx;
    logic             retire;
    logic             misaligned;
    logic [CNT_W-1:0] instret_nx;

    // Redirect target alignment check against the instruction size
    always_comb begin
        misaligned = redirect_valid && ((redirect_target & ALIGN_MASK) != '0);
    end

    // Next-state and next-datapath decision, RUN priority list
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        epc_nx        = epc;
        cause_nx      = cause;
        in_trap_nx    = in_trap;
        trap_taken_nx = 1'b0;
        retire        = 1'b0;
        unique case (state)
            RUN: begin
                if (halt_req) begin
                    state_nx = HALTED;
                end else if (trap_req || misaligned) begin
                    if (in_trap) begin
                        state_nx = LOCKED;
                    end else begin
                        epc_nx        = pc;
                        cause_nx      = trap_req ? 2'd1 : 2'd2;
                        pc_nx         = TRAP_VECTOR;
                        in_trap_nx    = 1'b1;
                        trap_taken_nx = 1'b1;
                    end
                end else if (trap_ret) begin
                    pc_nx      = epc;
                    in_trap_nx = 1'b0;
                    retire     = 1'b1;
                end else if (redirect_valid) begin
                    pc_nx  = redirect_target;
                    retire = 1'b1;
                end else if (!stall) begin
                    pc_nx  = pc + STEP;
                    retire = 1'b1;
                end
            end
            HALTED: begin
                if (resume_req) begin
                    state_nx = RUN;
                end
            end
            LOCKED: begin
                state_nx = LOCKED;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
        instret_nx = retire ? instret + CNT_W'(1) : instret;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Registered datapath and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_VECTOR;
            epc        <= '0;
            cause      <= '0;
            in_trap    <= 1'b0;
            trap_taken <= 1'b0;
            halted     <= 1'b0;
            locked     <= 1'b0;
            instret    <= '0;
        end else begin
            pc         <= pc_nx;
            epc        <= epc_nx;
            cause      <= cause_nx;
            in_trap    <= in_trap_nx;
            trap_taken <= trap_taken_nx;
            halted     <= (state_nx == HALTED);
            locked     <= (state_nx == LOCKED);
            instret    <= instret_nx;
        end
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle core, replacing the bare PC register. It holds the fetch address and steps it by one instruction per cycle. It also supports stall, branch/jump redirect, trap entry/return with a saved exception PC, debug halt/resume, lock-up on double fault, and a retired-instruction counter. It sits between the next-PC logic and instruction memory, and its trap and halt requests come from the control unit and the debug port.

## Interface
- XLEN, 32, address width in bits (≥ 8).
- RESET_VECTOR, 0, PC value loaded on reset; must be ILEN-aligned.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry; must be ILEN-aligned.
- ILEN, 4, instruction size in bytes, either 2 or 4; sets the sequential step and the alignment rule.
- CNT_W, 64, width of the retired-instruction counter.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC; no retire.
- redirect_valid  in  1  take redirect_target this cycle (branch/jump).
- redirect_target  in  XLEN  redirect address.
- trap_req  in  1  synchronous exception raised by the current instruction.
- trap_ret  in  1  return from trap (mret).
- halt_req  in  1  debug halt request (level).
- resume_req  in  1  debug resume (one-cycle pulse).
- pc  out  XLEN  current fetch address.
- epc  out  XLEN  saved exception PC.
- cause  out  2  0 = none, 1 = trap_req, 2 = misaligned redirect.
- trap_taken  out  1  one-cycle pulse; high in the first cycle that pc == TRAP_VECTOR after trap entry.
- halted  out  1  high while in HALTED.
- locked  out  1  high while in LOCKED.
- instret  out  CNT_W  count of retired instructions.

## Operation
FSM states:
- RUN: normal execution.
- HALTED: entered on debug halt.
- LOCKED: entered on double fault.

An internal in_trap flag is set on trap entry and cleared on trap_ret.

Cycle action in RUN, highest priority first:
1. halt_req: go to HALTED. pc is held and there is no retire. The instruction at pc is not retired.
2. trap_req, or redirect_valid with a misaligned target (any of target[log2(ILEN)-1:0] nonzero):
   - If in_trap is already set: go to LOCKED, pc held.
   - Otherwise: epc <= pc, cause <= 1 or 2 (trap_req wins over a misaligned redirect), pc <= TRAP_VECTOR, in_trap <= 1, no retire.
3. trap_ret: pc <= epc, in_trap <= 0, retire. If in_trap is clear, this is still legal and simply jumps to epc.
4. redirect_valid with an aligned target: pc <= redirect_target, retire.
5. stall: pc held, no retire.
6. Otherwise: pc <= pc + ILEN (modulo 2^XLEN, so wraps to 0), retire.

Other rules:
- HALTED: pc, epc, instret and in_trap are frozen. Every input except resume_req and reset is ignored. resume_req returns to RUN, and fetch continues at the held pc on the next cycle.
- LOCKED: everything is frozen and only reset exits.
- Retire means instret <= instret + 1, modulo 2^CNT_W.
- epc and cause change only on trap entry.

## Timing
- Reset (synchronous, sampled on the rising edge), after which:
  - pc = RESET_VECTOR, epc = 0, cause = 0, instret = 0
  - in_trap = 0, trap_taken = 0, halted = 0, locked = 0
  - state = RUN
- Reset overrides every other input in the same cycle, including mid-trap, HALTED and LOCKED.
- All outputs are registered. Decisions use inputs sampled at edge N and are visible after edge N.
- Redirect and trap latency is one cycle: a request seen at edge N gives the new pc after edge N.
- trap_taken is high for exactly one cycle, the cycle after entry, even if stall is asserted in that cycle.
- halted rises one cycle after the first edge where halt_req is sampled in RUN. It falls one cycle after resume_req is sampled in HALTED.
- If halt_req is still high at resume, the unit re-halts on the following edge. Only one RUN cycle is observable, and that cycle obeys the full RUN priority list.
- Simultaneous trap_req and trap_ret: the trap wins.
- Simultaneous stall and redirect: the redirect wins, because stall only blocks sequential advance.

## Test plan
- Reset then 4 free-running cycles, ILEN=4, RESET_VECTOR=0 -> pc = 0, 4, 8, 12, 16 and instret = 4.
- Redirect to 0x40 with stall asserted in the same cycle -> next pc = 0x40 and instret increments by 1. Stall alone for 3 cycles -> pc held at 0x40 and instret unchanged.
- Redirect to 0x42 (ILEN=4) at pc = 0x10 -> pc = 0x100, epc = 0x10, cause = 2, trap_taken pulses once. Then trap_ret -> pc = 0x10 and in_trap cleared.
- trap_req at pc = 0x20, then trap_req again before trap_ret -> first gives pc = 0x100; second gives locked = 1 with pc stuck at 0x100. Only reset restores pc = 0 and locked = 0.
- halt_req at pc = 0x8 for 5 cycles, with redirect and trap_req driven during the halt -> halted = 1, pc stays 0x8, instret frozen. resume_req with halt_req low -> pc = 0xC on the cycle after halted falls.
- pc = 2^XLEN − 4, no stall -> pc wraps to 0. CNT_W=4 with 16 retires -> instret wraps to 0. Reset asserted while in HALTED -> all outputs at their reset values on the next cycle.
